// File: rtl/alu_pkg.sv
// Shared opcode and sequencer state encodings for the ALU sequencer slice.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_ADD  = 3'b010,
    OP_LOAD = 3'b011,
    OP_XOR  = 3'b100,
    OP_NOR  = 3'b101,
    OP_SUB  = 3'b110,
    OP_SLT  = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU: logic ops, wrapping add/sub with carry/borrow and signed
// overflow, and signed set-less-than.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       f,
  output logic [WIDTH-1:0] y,
  output logic             overflow,
  output logic             carry,
  output logic             zero
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic           slt;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};
  assign slt  = $signed(a) < $signed(b);

  // For subtraction the carry flag reports a borrow (a < b unsigned).
  always_comb begin
    y        = '0;
    overflow = 1'b0;
    carry    = 1'b0;
    case (op_t'(f))
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOR:  y = ~(a | b);
      OP_ADD: begin
        y        = sum[WIDTH-1:0];
        carry    = sum[WIDTH];
        overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        y        = diff[WIDTH-1:0];
        carry    = diff[WIDTH];
        overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT:  y = {{(WIDTH-1){1'b0}}, slt};
      default: y = '0;
    endcase
  end

  assign zero = (y == '0);

endmodule

// File: rtl/alu_sequencer.sv
// Three-state command sequencer around a 4-entry register file: accept a
// command, run it through the shared ALU for one cycle, hold the response.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [1:0]       cmd_rd,
  input  logic [1:0]       cmd_ra,
  input  logic [1:0]       cmd_rb,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_f,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [2:0]       rsp_flags
);

  state_t           state;
  op_t              op_q;
  logic [1:0]       rd_q;
  logic [1:0]       ra_q;
  logic [1:0]       rb_q;
  logic [WIDTH-1:0] imm_q;
  logic [WIDTH-1:0] regs [4];

  logic [WIDTH-1:0] alu_y;
  logic             alu_v;
  logic             alu_c;
  logic             alu_z;
  logic [WIDTH-1:0] result;
  logic [2:0]       flags;

  // ALU operands are only live during EXEC; register reads see pre-writeback values.
  assign alu_a = (state == EXEC) ? regs[ra_q] : '0;
  assign alu_b = (state == EXEC) ? regs[rb_q] : '0;
  assign alu_f = (state == EXEC) ? op_q : 3'b000;

  alu #(.WIDTH(WIDTH)) u_alu (
    .a        (alu_a),
    .b        (alu_b),
    .f        (alu_f),
    .y        (alu_y),
    .overflow (alu_v),
    .carry    (alu_c),
    .zero     (alu_z)
  );

  always_comb begin
    result = alu_y;
    flags  = {alu_v, alu_c, alu_z};
    if (op_q == OP_LOAD) begin
      result = imm_q;
      flags  = {1'b0, 1'b0, (imm_q == '0)};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      op_q      <= OP_AND;
      rd_q      <= '0;
      ra_q      <= '0;
      rb_q      <= '0;
      imm_q     <= '0;
      rsp_data  <= '0;
      rsp_flags <= '0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            op_q      <= op_t'(cmd_op);
            rd_q      <= cmd_rd;
            ra_q      <= cmd_ra;
            rb_q      <= cmd_rb;
            imm_q     <= cmd_imm;
            cmd_ready <= 1'b0;
            state     <= EXEC;
          end
        end
        EXEC: begin
          regs[rd_q] <= result;
          rsp_data   <= result;
          rsp_flags  <= flags;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench: stimulus pushes reference-model results, an independent
// monitor pops and compares them as responses appear.
module tb_alu_sequencer;
  import alu_pkg::*;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [2:0]       cmd_op = 3'b000;
  logic [1:0]       cmd_rd = 2'd0;
  logic [1:0]       cmd_ra = 2'd0;
  logic [1:0]       cmd_rb = 2'd0;
  logic [WIDTH-1:0] cmd_imm = '0;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_f;
  logic             rsp_valid;
  logic             rsp_ready = 1'b1;
  logic [WIDTH-1:0] rsp_data;
  logic [2:0]       rsp_flags;

  alu_sequencer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_rd    (cmd_rd),
    .cmd_ra    (cmd_ra),
    .cmd_rb    (cmd_rb),
    .cmd_imm   (cmd_imm),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_f     (alu_f),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_flags (rsp_flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [2:0]       flags;
    int               acceptEdge;
  } exp_t;

  exp_t             q[$];
  logic [WIDTH-1:0] model [4];
  int               checks = 0;
  int               errors = 0;
  int               cyc = 0;
  int               lastAccept = 0;
  int               rspMode = 0;
  bit               seen = 0;

  always @(posedge clk) cyc++;

  // Consumer readiness: 0 = always ready, 1 = stalled, 2 = random.
  always @(negedge clk) begin
    case (rspMode)
      0:       rsp_ready = 1'b1;
      1:       rsp_ready = 1'b0;
      default: rsp_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int sx(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? int'(v) - (1 << WIDTH) : int'(v);
  endfunction

  // Reference result from the arithmetic definition of each operation.
  task automatic refModel(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] imm, output logic [WIDTH-1:0] data, output logic [2:0] flags);
    int  s;
    int  ss;
    bit  v = 0;
    bit  c = 0;
    case (op)
      OP_AND:  data = a & b;
      OP_OR:   data = a | b;
      OP_XOR:  data = a ^ b;
      OP_NOR:  data = ~(a | b);
      OP_LOAD: data = imm;
      OP_ADD: begin
        s    = int'(a) + int'(b);
        ss   = sx(a) + sx(b);
        data = WIDTH'(s);
        c    = (s >= (1 << WIDTH));
        v    = (ss > (1 << (WIDTH-1)) - 1) || (ss < -(1 << (WIDTH-1)));
      end
      OP_SUB: begin
        s    = int'(a) - int'(b);
        ss   = sx(a) - sx(b);
        data = WIDTH'(s);
        c    = (a < b);
        v    = (ss > (1 << (WIDTH-1)) - 1) || (ss < -(1 << (WIDTH-1)));
      end
      default: data = (sx(a) < sx(b)) ? 1 : 0;
    endcase
    flags = {v, c, (data == 0)};
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] ra,
                               input logic [1:0] rb, input logic [WIDTH-1:0] imm);
    exp_t e;
    bit   ok = 0;
    refModel(op, model[ra], model[rb], imm, e.data, e.flags);
    @(negedge clk);
    cmd_op = op; cmd_rd = rd; cmd_ra = ra; cmd_rb = rb; cmd_imm = imm;
    cmd_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (cmd_ready) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checkOutput("accept_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    e.acceptEdge = cyc + 1;
    lastAccept   = e.acceptEdge;
    q.push_back(e);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    checkOutput("exec_alu_a", 32'(alu_a), 32'(model[ra]));
    checkOutput("exec_alu_b", 32'(alu_b), 32'(model[rb]));
    checkOutput("exec_alu_f", 32'(alu_f), 32'(op));
    model[rd] = e.data;
  endtask

  task automatic waitRspValid();
    bit ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) checkOutput("rsp_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 300 && q.size() != 0; i++) @(negedge clk);
    checkOutput("drain_queue", 32'(q.size()), 32'd0);
  endtask

  // Monitor: checks every presented response cycle, pops on handshake.
  always @(negedge clk) begin
    if (!reset) begin
      if (rsp_valid) begin
        if (q.size() == 0) begin
          checkOutput("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          if (!seen) begin
            checkOutput("rsp_latency", 32'((cyc + 1) - q[0].acceptEdge), 32'd2);
            seen = 1;
          end
          checkOutput("rsp_data", 32'(rsp_data), 32'(q[0].data));
          checkOutput("rsp_flags", 32'(rsp_flags), 32'(q[0].flags));
          checkOutput("cmd_ready_in_resp", 32'(cmd_ready), 32'd0);
          if (rsp_ready) begin
            void'(q.pop_front());
            seen = 0;
          end
        end
      end else if (cmd_ready) begin
        checkOutput("alu_idle_zero", {13'd0, alu_f, alu_a | alu_b}, 32'd0);
      end
    end
  end

  initial begin
    int prevAccept;
    for (int i = 0; i < 4; i++) model[i] = '0;

    // Reset state
    #12;
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_rsp_data", 32'(rsp_data), 32'd0);
    checkOutput("reset_rsp_flags", 32'(rsp_flags), 32'd0);
    checkOutput("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("post_reset_cmd_ready", 32'(cmd_ready), 32'd1);

    // Overflow, zero, borrow and signed compare cases
    applyStimulus(OP_LOAD, 2'd1, 2'd0, 2'd0, 16'h7FFF);
    applyStimulus(OP_LOAD, 2'd2, 2'd0, 2'd0, 16'h0001);
    applyStimulus(OP_ADD,  2'd3, 2'd1, 2'd2, 16'h0000);
    applyStimulus(OP_SUB,  2'd0, 2'd2, 2'd2, 16'h0000);
    applyStimulus(OP_LOAD, 2'd1, 2'd0, 2'd0, 16'h0002);
    applyStimulus(OP_SUB,  2'd0, 2'd2, 2'd1, 16'h0000);
    applyStimulus(OP_LOAD, 2'd1, 2'd0, 2'd0, 16'hFFFE);
    applyStimulus(OP_LOAD, 2'd2, 2'd0, 2'd0, 16'h0003);
    applyStimulus(OP_SLT,  2'd3, 2'd1, 2'd2, 16'h0000);
    applyStimulus(OP_SLT,  2'd3, 2'd2, 2'd1, 16'h0000);
    applyStimulus(OP_LOAD, 2'd0, 2'd0, 2'd0, 16'h0000);
    applyStimulus(OP_ADD,  2'd2, 2'd2, 2'd2, 16'h0000);
    waitDrain();
    checkOutput("overflow_model", {model[3], 16'h0}, {16'h0000, 16'h0});

    // Backpressure: five stalled cycles with a dropped command in the middle
    rspMode = 1;
    @(negedge clk);
    applyStimulus(OP_OR, 2'd3, 2'd1, 2'd2, 16'h0000);
    waitRspValid();
    for (int k = 0; k < 5; k++) begin
      checkOutput("stall_cmd_ready", 32'(cmd_ready), 32'd0);
      if (k == 2) begin
        cmd_op = OP_LOAD; cmd_rd = 2'd1; cmd_imm = 16'hDEAD; cmd_valid = 1'b1;
      end
      if (k == 3) cmd_valid = 1'b0;
      @(negedge clk);
    end
    rspMode = 0;
    applyStimulus(OP_OR, 2'd0, 2'd1, 2'd1, 16'h0000);
    waitDrain();

    // Throughput with the consumer always ready
    applyStimulus(OP_XOR, 2'd0, 2'd1, 2'd2, 16'h0000);
    for (int i = 0; i < 6; i++) begin
      prevAccept = lastAccept;
      applyStimulus(3'(i), 2'(i), 2'(i + 1), 2'(i + 2), 16'(16'h1111 * i));
      checkOutput("accept_spacing", 32'(lastAccept - prevAccept), 32'd3);
    end
    waitDrain();

    // Reset during RESP aborts the response and clears all registers
    rspMode = 1;
    @(negedge clk);
    applyStimulus(OP_LOAD, 2'd1, 2'd0, 2'd0, 16'h1234);
    waitRspValid();
    #2;
    reset = 1'b1;
    #1;
    checkOutput("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("abort_rsp_data", 32'(rsp_data), 32'd0);
    q.delete();
    seen = 0;
    for (int i = 0; i < 4; i++) model[i] = '0;
    rspMode = 0;
    @(negedge clk);
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    applyStimulus(OP_AND, 2'd0, 2'd1, 2'd2, 16'h0000);
    waitDrain();

    // Randomized traffic with random consumer backpressure
    rspMode = 2;
    for (int i = 0; i < 150; i++) begin
      applyStimulus(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    2'($urandom_range(0, 3)), 16'($urandom));
    end
    waitDrain();
    rspMode = 0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter: WIDTH, default 16, data width of registers, ALU operands and response data.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 cmd_valid  input  1  command offered.
REQ-005 cmd_ready  output  1  sequencer can accept a command.
REQ-006 cmd_op  input  3  operation: 000 AND, 001 OR, 010 ADD, 011 LOAD, 100 XOR, 101 NOR, 110 SUB, 111 SLT.
REQ-007 cmd_rd / cmd_ra / cmd_rb  input  2 each  destination, source-A and source-B register index.
REQ-008 cmd_imm  input  WIDTH  immediate value, used by LOAD only.
REQ-009 alu_a / alu_b  output  WIDTH  operands to the ALU instance.
REQ-010 alu_f  output  3  ALU function code, equal to the latched op.
REQ-011 rsp_valid  input/output: output  1  result available.
REQ-012 rsp_ready  input  1  consumer accepts result.
REQ-013 rsp_data  output  WIDTH  value written to rd.
REQ-014 rsp_flags  output  3  {overflow, carry, zero} of this operation.

Function
REQ-015 FSM states IDLE, EXEC, RESP; cmd_ready = 1 only in IDLE; rsp_valid = 1 only in RESP.
REQ-016 IDLE: on cmd_valid && cmd_ready, latch op, rd, ra, rb, imm; go to EXEC.
REQ-017 EXEC (exactly one cycle): alu_a = R[ra], alu_b = R[rb], alu_f = op; at end of cycle write result to R[rd], capture rsp_data and rsp_flags, go to RESP.
REQ-018 Outside EXEC, alu_a, alu_b and alu_f SHALL be driven to 0.
REQ-019 Non-LOAD ops: result = ALU y; flags = ALU {overflow, carry_out, zero}, unmodified.
REQ-020 LOAD: result = latched imm, ALU output ignored; overflow = 0, carry = 0, zero = (imm == 0).
REQ-021 RESP: rsp_data and rsp_flags held stable until rsp_ready sampled high; then go to IDLE.
REQ-022 Latency: command accepted at edge N -> rsp_valid high from edge N+2; minimum 3 cycles per command.
REQ-023 ra, rb and rd may be equal; operands read pre-writeback values of EXEC cycle.
REQ-024 Commands presented while cmd_ready = 0 SHALL be ignored and not latched.
REQ-025 Register file: 4 x WIDTH, written only at EXEC->RESP transition, never in other states.
REQ-026 Arithmetic wraps modulo 2^WIDTH; no saturation.

Reset
REQ-027 On reset assertion, immediately: state = IDLE, R[0..3] = 0, rsp_data = 0, rsp_flags = 0, latched command fields = 0.
REQ-028 Reset during EXEC or RESP SHALL abort the operation with no register write and rsp_valid = 0 in the same cycle.
REQ-029 After reset deassertion, cmd_ready = 1 on first active clock edge.

Structure
REQ-030 Shared package alu_pkg SHALL hold the opcode enum (3-bit, values per REQ-006) and the state enum (IDLE, EXEC, RESP).
REQ-031 The existing alu module SHALL be instantiated once as sub-module u_alu with WIDTH passed through; no arithmetic is duplicated in the sequencer.

Verification
REQ-032 Reset: assert reset mid-RESP -> rsp_valid = 0, cmd_ready = 1 after release, all registers read 0 via AND r0=r1&r2 -> rsp_data 0x0000, flags 3'b001.
REQ-033 Overflow: LOAD r1=0x7FFF, LOAD r2=0x0001, ADD r3=r1+r2 -> rsp_data 0x8000, flags {V=1,C=0,Z=0}.
REQ-034 Zero/borrow: SUB r0=r2-r2 -> 0x0000, flags {0,0,1}; SUB r0=r2-r1 with r1=0x0002, r2=0x0001 -> 0xFFFF, carry = 1.
REQ-035 SLT: r1=0xFFFE, r2=0x0003, SLT r3=r1<r2 -> rsp_data 0x0001; swap operands -> 0x0000, zero = 1.
REQ-036 Backpressure: rsp_ready low 5 cycles -> rsp_data/rsp_flags stable, cmd_ready 0, a cmd_valid pulse during the stall is dropped and no register changes.
REQ-037 Throughput: back-to-back commands with rsp_ready tied high -> one accepted per 3 cycles, rsp_valid asserted exactly 2 cycles after each acceptance.
